// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes on both sides.
//   Stage 1 registers the per-bit generate/propagate terms, the per-group
//           G/P terms, the carry-in and the operand sign bits.
//   Stage 2 forms group carries by lookahead over the group G/P terms, then
//           intra-group carries by lookahead, and registers sum/cout/ovf.
// A transfer occurs on any rising edge where valid && ready.
//
// Parameters
//   WIDTH  operand/result width, 8..64
//   GROUP  lookahead group size; WIDTH must be a multiple of GROUP
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set presented
//   in_ready   block accepts operands this cycle (comb from out_ready only)
//   a, b       operands
//   sub        1: a - b, 0: a + b
//   cin        carry-in, add mode only (ignored when sub = 1)
//   out_valid  result present
//   out_ready  consumer accepts result
//   sum        result
//   cout       carry-out of the MSB; in subtract mode 1 = no borrow
//   ovf        signed two's-complement overflow
//
// Configuration
//   PIPELINED_CLA_ADDER_SAT_EN  when defined, a signed overflow clamps sum to
//                               the most positive / most negative value; ovf
//                               is still reported and cout is unchanged.
// -----------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0) begin : g_bad_group
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
    end

    // Carry into position n of a g/p vector with carry-in c_in, written as a
    // flat sum of products so no ripple chain is built:
    //   c[n] = g[n-1] | p[n-1]g[n-2] | ... | p[n-1..0]c_in
    function automatic logic la_carry(input logic [WIDTH-1:0] g,
                                      input logic [WIDTH-1:0] p,
                                      input logic             c_in,
                                      input int               n);
        logic c;
        logic prod;
        c = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            if (j < n) begin
                prod = g[j];
                for (int k = j + 1; k < WIDTH; k++) begin
                    if (k < n) prod = prod & p[k];
                end
                c = c | prod;
            end
        end
        prod = c_in;
        for (int k = 0; k < WIDTH; k++) begin
            if (k < n) prod = prod & p[k];
        end
        return c | prod;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: operand conditioning and generate/propagate terms
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic [NG-1:0]    gg_in;
    logic [NG-1:0]    gp_in;
    logic             c0_in;

    // Subtraction is a + ~b + 1, so the carry-in is forced to 1.
    assign b_eff = sub ? ~b : b;
    assign g_in  = a & b_eff;
    assign p_in  = a ^ b_eff;
    assign c0_in = sub | cin;

    // NOTE: every signal driven here gets a default first so no latch can
    // be inferred on any path through the loop.
    always_comb begin
        gg_in = '0;
        gp_in = '0;
        for (int k = 0; k < NG; k++) begin
            gp_in[k] = &p_in[k*GROUP +: GROUP];
            gg_in[k] = la_carry(WIDTH'(g_in[k*GROUP +: GROUP]),
                                WIDTH'(p_in[k*GROUP +: GROUP]), 1'b0, GROUP);
        end
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic [NG-1:0]    s1_gg;
    logic [NG-1:0]    s1_gp;
    logic             s1_c0;
    logic             s1_sa;
    logic             s1_sb;
    logic             s1_adv;

    // Stage 1 may hand its content on whenever stage 2 is empty or draining.
    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    // NOTE: the datapath registers are reset as well so the outputs read zero
    // during and after reset rather than stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_gg    <= '0;
            s1_gp    <= '0;
            s1_c0    <= 1'b0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_g  <= g_in;
                s1_p  <= p_in;
                s1_gg <= gg_in;
                s1_gp <= gp_in;
                s1_c0 <= c0_in;
                s1_sa <= a[WIDTH-1];
                s1_sb <= b_eff[WIDTH-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: group carries, intra-group carries, sum and flags
    // ------------------------------------------------------------------
    logic [NG:0]      grp_c;   // grp_c[k] = carry into group k, grp_c[NG] = cout
    logic [WIDTH-1:0] c_vec;
    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] sum_nxt;
    logic             ovf_nxt;

    always_comb begin
        grp_c = '0;
        c_vec = '0;
        for (int k = 0; k <= NG; k++) begin
            grp_c[k] = la_carry(WIDTH'(s1_gg), WIDTH'(s1_gp), s1_c0, k);
        end
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < GROUP; i++) begin
                c_vec[k*GROUP+i] = la_carry(WIDTH'(s1_g[k*GROUP +: GROUP]),
                                            WIDTH'(s1_p[k*GROUP +: GROUP]),
                                            grp_c[k], i);
            end
        end
    end

    assign sum_raw = s1_p ^ c_vec;
    assign ovf_nxt = (s1_sa == s1_sb) && (sum_raw[WIDTH-1] != s1_sa);

`ifdef PIPELINED_CLA_ADDER_SAT_EN
    // Overflow always has the sign opposite to both operands; clamp towards
    // the operand sign.
    always_comb begin
        sum_nxt = sum_raw;
        if (ovf_nxt) begin
            sum_nxt = s1_sa ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_nxt = sum_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_nxt;
                cout <= grp_c[NG];
                ovf  <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Directed self-checking bench for pipelined_cla_adder at WIDTH=16, GROUP=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

    localparam int W = 16;

`ifdef PIPELINED_CLA_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running required=done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s, input logic ci);
        logic [W:0]   t;
        logic [W-1:0] r;
        int           ix;
        int           iy;
        int           exact;
        logic         o;
        ix = $signed(x);
        iy = $signed(y);
        if (s) begin
            t     = {1'b0, x} + {1'b0, ~y} + 17'd1;
            exact = ix - iy;
        end else begin
            t     = {1'b0, x} + {1'b0, y} + {16'd0, ci};
            exact = ix + iy + int'(ci);
        end
        o = (exact > 32767) || (exact < -32768);
        r = t[W-1:0];
        if (SAT && o) r = (exact > 0) ? 16'h7FFF : 16'h8000;
        return {o, t[W], r};
    endfunction

    // One isolated transfer into an empty pipeline; checks the 2-cycle latency.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic ci,
                          input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
        a = x; b = y; sub = s; cin = ci;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "/early_valid"}, {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        check({tag, "/valid"}, {15'd0, out_valid}, 16'd1);
        check({tag, "/sum"},   sum, e_sum);
        check({tag, "/cout"},  {15'd0, cout}, {15'd0, e_cout});
        check({tag, "/ovf"},   {15'd0, ovf},  {15'd0, e_ovf});
        @(negedge clk);
    endtask

    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic         vc [8];
    logic [W+1:0] exp_r;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         stalled;
    logic         seen;
    int           sent;
    int           got;
    int           cyc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst/out_valid", {15'd0, out_valid}, 16'd0);
        check("rst/sum",       sum, 16'h0000);
        check("rst/cout",      {15'd0, cout}, 16'd0);
        check("rst/ovf",       {15'd0, ovf},  16'd0);
        rst = 1'b0;
        #1;
        check("rst/in_ready",  {15'd0, in_ready}, 16'd1);
        @(negedge clk);

        // Directed arithmetic
        run_op("add_basic", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_povf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_novf",  16'h8000, 16'h0001, 1'b1, 1'b0, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
        run_op("add_cin",   16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0);
        run_op("sub_igncin",16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("add_grp",   16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("add_novf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000 & (SAT ? 16'hFFFF : 16'h0000), 1'b1, 1'b1);

        // Backpressure stream: 8 operand pairs, random out_ready
        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vc[i] = 1'($urandom);
        end
        sent = 0; got = 0; cyc = 0; stalled = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        while (got < 8 && cyc < 300) begin
            if (stalled) begin
                check("bp/hold_valid", {15'd0, out_valid}, 16'd1);
                check("bp/hold_sum",   sum, prev_sum);
                check("bp/hold_cout",  {15'd0, cout}, {15'd0, prev_cout});
            end
            out_ready = 1'($urandom);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                a = va[sent]; b = vb[sent]; cin = vc[sent]; sub = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                exp_r = model(va[got], vb[got], 1'b0, vc[got]);
                check("bp/sum",  sum, exp_r[W-1:0]);
                check("bp/cout", {15'd0, cout}, {15'd0, exp_r[W]});
                check("bp/ovf",  {15'd0, ovf},  {15'd0, exp_r[W+1]});
                got++;
            end
            if (in_valid && in_ready) sent++;
            stalled   = out_valid && !out_ready;
            prev_sum  = sum;
            prev_cout = cout;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp/count", 16'(got), 16'd8);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Mid-flight reset: two operands accepted, output stalled
        out_ready = 1'b0;
        in_valid  = 1'b1; a = 16'h0001; b = 16'h0002; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        a = 16'h0003; b = 16'h0004;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mid/full_valid", {15'd0, out_valid}, 16'd1);
        check("mid/full_ready", {15'd0, in_ready},  16'd0);
        rst = 1'b1;
        #1;
        check("mid/rst_valid", {15'd0, out_valid}, 16'd0);
        check("mid/rst_sum",   sum, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mid/no_ghost", {15'd0, seen}, 16'd0);
        check("mid/in_ready", {15'd0, in_ready}, 16'd1);
        run_op("mid/recover", 16'h00AA, 16'h0055, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand/result width in bits, legal range 8..64.
REQ-002 The block SHALL have parameter GROUP, default 4: lookahead group size in bits; WIDTH SHALL be an integer multiple of GROUP.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand set presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port sub, input, 1 bit: 1 selects A-B, 0 selects A+B.
REQ-010 The block SHALL have port cin, input, 1 bit: carry-in, add mode only; ignored when sub=1.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: result.
REQ-014 The block SHALL have port cout, output, 1 bit: carry-out of MSB; in sub mode, 1 = no borrow.
REQ-015 The block SHALL have port ovf, output, 1 bit: signed two's-complement overflow.

Function
REQ-016 Transfer in SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-017 Stage 1 SHALL register per-bit generate (a&b') and XOR propagate (a^b'), with b' = sub ? ~b : b and c0 = sub ? 1 : cin; it SHALL also register per-group G/P and the MSB operand signs.
REQ-018 Stage 2 SHALL compute group carries by lookahead over group G/P, then intra-group carries by lookahead; sum = p ^ c; the result SHALL be registered.
REQ-019 No ripple chain longer than GROUP bits SHALL exist in either stage.
REQ-020 Latency SHALL be 2 cycles from input transfer to out_valid with no backpressure; sustained throughput SHALL be 1 result per cycle.
REQ-021 Stage 1 SHALL advance when stage 2 is empty or out_ready=1.
REQ-022 in_ready SHALL equal !s1_valid || stage-1 advance; it SHALL be combinational from out_ready, with no comb path from in_valid.
REQ-023 While out_valid=1 && out_ready=0, sum/cout/ovf SHALL hold stable and no operand SHALL be lost or duplicated.
REQ-024 Simultaneous input and output transfers in the same cycle SHALL both complete; results SHALL stay in order.
REQ-025 ovf SHALL be (sa == sb') && (sum[MSB] != sa).
REQ-026 Arithmetic SHALL be modulo 2^WIDTH: all-ones + 1 gives sum=0, cout=1.

Reset
REQ-027 Asserting rst SHALL immediately clear all valid bits and drive out_valid=0, sum=0, cout=0, ovf=0; in_ready SHALL be 1 after rst deasserts.
REQ-028 Reset asserted mid-operation SHALL discard in-flight results; no result SHALL appear after deassertion without a new input transfer.

Configuration
REQ-029 When macro PIPELINED_CLA_ADDER_SAT_EN is defined, a signed overflow SHALL clamp sum to 0x7F..F (positive overflow) or 0x80..0 (negative overflow), with ovf still reported and cout unchanged.
REQ-030 When PIPELINED_CLA_ADDER_SAT_EN is undefined, sum SHALL wrap and no saturation logic SHALL be present.

Verification (WIDTH=16, GROUP=4)
REQ-031 Reset test: rst pulse -> out_valid=0, sum=0x0000, in_ready=1.
REQ-032 Single add: a=0x00FF, b=0x0001, sub=0, cin=0 -> 2 cycles later sum=0x0100, cout=0, ovf=0.
REQ-033 Wrap and overflow: 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0; 0x7FFF+0x0001 -> sum=0x8000 (0x7FFF with SAT_EN), ovf=1.
REQ-034 Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0; 0x8000-0x0001 -> ovf=1, sum=0x7FFF (0x8000 with SAT_EN).
REQ-035 Backpressure: stream 8 random operand pairs with out_ready toggled randomly -> all 8 results in order, matching a+b+cin mod 2^16, none dropped, outputs stable while stalled.
REQ-036 Mid-flight reset: two operands accepted, rst asserted for one cycle -> no out_valid afterwards until the next input transfer.
